// File: rtl/raycast_pkg.sv
// Shared raycaster types: screen geometry, pixel type, DDA hit record and
// the column_writer state encoding.
package raycast_pkg;

  localparam int SCREEN_WIDTH  = 320;
  localparam int SCREEN_HEIGHT = 240;

  typedef logic [7:0] pixel_t;

  typedef struct packed {
    logic [8:0] hcount;
    logic [7:0] lineHeight;
    logic       wallType;
    logic [3:0] mapData;
    logic [7:0] wallX;
  } dda_result_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WRITE,
    ST_DONE
  } cw_state_t;

endpackage

// File: rtl/dda_result_slot.sv
// One-entry holding buffer between the DDA and the column writer.
// A push that lands on a full slot without a matching pop is dropped and latched as overflow.
module dda_result_slot
  import raycast_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  dda_result_t din,
  output dda_result_t dout,
  output logic        full,
  output logic        overflow
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // A simultaneous pop frees the entry, so the new result can take its place.
      if (push && (!full || pop)) begin
        dout <= din;
        full <= 1'b1;
      end else if (pop) begin
        full <= 1'b0;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/column_writer.sv
// Expands one DDA hit into a full framebuffer column: ceiling, wall, floor rows.
// Define COLUMN_WRITER_Y_SHADE_EN to draw Y-side walls in the darker half of the shade range.
module column_writer #(
  parameter int                 SCREEN_WIDTH  = raycast_pkg::SCREEN_WIDTH,
  parameter int                 SCREEN_HEIGHT = raycast_pkg::SCREEN_HEIGHT,
  parameter raycast_pkg::pixel_t CEIL_COLOR   = 8'h11,
  parameter raycast_pkg::pixel_t FLOOR_COLOR  = 8'h22
) (
  input  logic                                         pixel_clk_in,
  input  logic                                         rst_in,
  input  logic                                         dda_valid_in,
  input  logic [8:0]                                   hcount_ray_in,
  input  logic [7:0]                                   lineHeight_in,
  input  logic                                         wallType_in,
  input  logic [3:0]                                   mapData_in,
  input  logic [7:0]                                   wallX_in,
  input  logic                                         fb_ready_in,
  output logic [$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)-1:0] fb_addr_out,
  output raycast_pkg::pixel_t                          fb_data_out,
  output logic                                         fb_we_out,
  output logic                                         busy_out,
  output logic                                         column_done_out,
  output logic                                         overflow_out
);
  import raycast_pkg::*;

  localparam int ADDR_W = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT);
  localparam int Y_W    = $clog2(SCREEN_HEIGHT+1);

  cw_state_t   state;
  dda_result_t cur;
  dda_result_t slot_data;
  dda_result_t new_result;
  logic        slot_full;
  logic        pop;
  logic [Y_W-1:0] y;
  logic [Y_W-1:0] line_h;
  logic [Y_W-1:0] h;
  logic [Y_W-1:0] draw_start;
  logic [Y_W-1:0] draw_stop;
  logic [Y_W-1:0] next_row;
  pixel_t      wall_pixel;
  pixel_t      next_pixel;
  logic        unused_bits;

  assign new_result = '{hcount: hcount_ray_in, lineHeight: lineHeight_in, wallType: wallType_in,
                        mapData: mapData_in, wallX: wallX_in};
  assign pop = slot_full && (state == ST_IDLE || state == ST_DONE);
  assign busy_out = slot_full;

  dda_result_slot u_slot (
    .clk      (pixel_clk_in),
    .rst_n    (rst_in),
    .push     (dda_valid_in),
    .pop      (pop),
    .din      (new_result),
    .dout     (slot_data),
    .full     (slot_full),
    .overflow (overflow_out)
  );

  // Wall span derived from the working result; draw_stop is exclusive so h==0 yields no wall rows.
  assign line_h     = Y_W'(cur.lineHeight);
  assign h          = (line_h > Y_W'(SCREEN_HEIGHT)) ? Y_W'(SCREEN_HEIGHT) : line_h;
  assign draw_start = (Y_W'(SCREEN_HEIGHT) - h) >> 1;
  assign draw_stop  = draw_start + h;
  assign next_row   = (state == ST_WRITE) ? y + 1'b1 : '0;

`ifdef COLUMN_WRITER_Y_SHADE_EN
  assign wall_pixel = cur.wallType ? {cur.mapData, 1'b0, cur.wallX[7:5]}
                                   : {cur.mapData, cur.wallX[7:4]};
`else
  assign wall_pixel = {cur.mapData, cur.wallX[7:4]};
`endif
  assign unused_bits = ^{cur.wallX[3:0], cur.wallType};

  always_comb begin
    next_pixel = FLOOR_COLOR;
    if (next_row < draw_start) begin
      next_pixel = CEIL_COLOR;
    end else if (next_row < draw_stop) begin
      next_pixel = wall_pixel;
    end
  end

  // Outputs are registered one row ahead so a stalled write holds address and data steady.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= ST_IDLE;
      cur             <= '0;
      y               <= '0;
      fb_addr_out     <= '0;
      fb_data_out     <= '0;
      fb_we_out       <= 1'b0;
      column_done_out <= 1'b0;
    end else begin
      column_done_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (slot_full) begin
            cur   <= slot_data;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          y           <= '0;
          fb_addr_out <= ADDR_W'(cur.hcount);
          fb_data_out <= next_pixel;
          fb_we_out   <= 1'b1;
          state       <= ST_WRITE;
        end
        ST_WRITE: begin
          if (fb_ready_in) begin
            if (y == Y_W'(SCREEN_HEIGHT-1)) begin
              fb_we_out       <= 1'b0;
              column_done_out <= 1'b1;
              state           <= ST_DONE;
            end else begin
              y           <= next_row;
              fb_addr_out <= fb_addr_out + ADDR_W'(SCREEN_WIDTH);
              fb_data_out <= next_pixel;
            end
          end
        end
        ST_DONE: begin
          if (slot_full) begin
            cur   <= slot_data;
            state <= ST_SETUP;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
